// File: rtl/ddr_req_arbiter_2ch_if.sv
// ddr_req_arbiter_2ch_if: requester-side and avalon_mm_ddr-side signals of the two-port DDR arbiter
interface ddr_req_arbiter_2ch_if #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 256,
  parameter int BE_W   = 32
);
  logic [1:0]          rq_wr;
  logic [1:0]          rq_rd;
  logic [2*ADDR_W-1:0] rq_adr;
  logic [2*DATA_W-1:0] rq_wr_data;
  logic [2*BE_W-1:0]   rq_byte_enable;
  logic [1:0]          rq_ack;
  logic [1:0]          rq_done;
  logic [1:0]          rq_err;
  logic [1:0]          rq_rd_valid;
  logic [DATA_W-1:0]   rq_rd_data;
  logic                busy;
  logic                grant;
  logic                wr_rq;
  logic                rd_rq;
  logic [ADDR_W-1:0]   wr_adr;
  logic [ADDR_W-1:0]   rd_adr;
  logic [DATA_W-1:0]   wr_data;
  logic [BE_W-1:0]     byte_enable;
  logic                rd_valid;
  logic [DATA_W-1:0]   rd_data;
  logic                action_done;
  modport slave (
    input  rq_wr, rq_rd, rq_adr, rq_wr_data, rq_byte_enable, rd_valid, rd_data, action_done,
    output rq_ack, rq_done, rq_err, rq_rd_valid, rq_rd_data, busy, grant,
           wr_rq, rd_rq, wr_adr, rd_adr, wr_data, byte_enable
  );
  modport master (
    output rq_wr, rq_rd, rq_adr, rq_wr_data, rq_byte_enable, rd_valid, rd_data, action_done,
    input  rq_ack, rq_done, rq_err, rq_rd_valid, rq_rd_data, busy, grant,
           wr_rq, rd_rq, wr_adr, rd_adr, wr_data, byte_enable
  );
endinterface

// File: rtl/ddr_req_arbiter_2ch.sv
// ddr_req_arbiter_2ch: round-robin sharing of the avalon_mm_ddr port between two requesters with watchdog abort
module ddr_req_arbiter_2ch #(
  parameter int ADDR_W  = 25,
  parameter int DATA_W  = 256,
  parameter int BE_W    = 32,
  parameter int TIMEOUT = 1023
) (
  input logic avalon_clk,
  input logic avalon_reset,
  ddr_req_arbiter_2ch_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t            state;
  logic              prio;
  logic              op_rd;
  logic [9:0]        wd;
  logic [ADDR_W-1:0] adr_q;
  logic [DATA_W-1:0] data_q;
  logic [BE_W-1:0]   be_q;
  logic [1:0]        pend;
  logic              sel;
  logic [1:0]        own;
  always_comb begin
    pend = bus.rq_wr | bus.rq_rd;
    sel  = (&pend) ? prio : pend[1];
    own  = bus.grant ? 2'b10 : 2'b01;
  end
  assign bus.wr_adr      = adr_q;
  assign bus.rd_adr      = adr_q;
  assign bus.wr_data     = data_q;
  assign bus.byte_enable = be_q;
  always_ff @(posedge avalon_clk) begin
    if (avalon_reset) begin
      state           <= IDLE;
      prio            <= 1'b0;
      op_rd           <= 1'b0;
      wd              <= '0;
      adr_q           <= '0;
      data_q          <= '0;
      be_q            <= '0;
      bus.rq_ack      <= '0;
      bus.rq_done     <= '0;
      bus.rq_err      <= '0;
      bus.rq_rd_valid <= '0;
      bus.rq_rd_data  <= '0;
      bus.busy        <= 1'b0;
      bus.grant       <= 1'b0;
      bus.wr_rq       <= 1'b0;
      bus.rd_rq       <= 1'b0;
    end else begin
      bus.rq_ack      <= '0;
      bus.rq_done     <= '0;
      bus.rq_err      <= '0;
      bus.wr_rq       <= 1'b0;
      bus.rd_rq       <= 1'b0;
      bus.rq_rd_valid <= (bus.rd_valid && state == WAIT && op_rd) ? own : 2'b00;
      bus.rq_rd_data  <= bus.rd_data;
      case (state)
        IDLE: if (|pend) begin
          // a port raising both wr and rd gets its write first; the read stays pending
          bus.grant  <= sel;
          op_rd      <= ~bus.rq_wr[sel];
          adr_q      <= sel ? bus.rq_adr[2*ADDR_W-1:ADDR_W] : bus.rq_adr[ADDR_W-1:0];
          data_q     <= sel ? bus.rq_wr_data[2*DATA_W-1:DATA_W] : bus.rq_wr_data[DATA_W-1:0];
          be_q       <= sel ? bus.rq_byte_enable[2*BE_W-1:BE_W] : bus.rq_byte_enable[BE_W-1:0];
          bus.rq_ack <= sel ? 2'b10 : 2'b01;
          bus.wr_rq  <= bus.rq_wr[sel];
          bus.rd_rq  <= ~bus.rq_wr[sel];
          bus.busy   <= 1'b1;
          state      <= ISSUE;
        end
        ISSUE: begin
          wd    <= '0;
          state <= WAIT;
        end
        WAIT: if (bus.action_done || wd == 10'(TIMEOUT - 1)) begin
          bus.rq_done <= own;
          bus.rq_err  <= bus.action_done ? 2'b00 : own;
          prio        <= ~bus.grant;
          bus.busy    <= 1'b0;
          state       <= IDLE;
        end else begin
          wd <= wd + 10'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ddr_req_arbiter_2ch.sv
// tb_ddr_req_arbiter_2ch: directed and randomized transactions checked against a transaction-level arbitration model
module tb_ddr_req_arbiter_2ch;
  localparam int TMO = 16;
  logic avalon_clk = 1'b0;
  logic avalon_reset = 1'b1;
  int total = 0;
  int bad = 0;
  ddr_req_arbiter_2ch_if #(.ADDR_W(25), .DATA_W(256), .BE_W(32)) b ();
  ddr_req_arbiter_2ch #(.ADDR_W(25), .DATA_W(256), .BE_W(32), .TIMEOUT(TMO)) dut (
    .avalon_clk(avalon_clk),
    .avalon_reset(avalon_reset),
    .bus(b)
  );
  always #5 avalon_clk = ~avalon_clk;
  bit [1:0]     m_wr, m_rd;
  bit           m_prio;
  logic [24:0]  m_adr [2];
  logic [255:0] m_dat [2];
  logic [31:0]  m_be  [2];
  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive();
    b.rq_wr = m_wr;
    b.rq_rd = m_rd;
    b.rq_adr = {m_adr[1], m_adr[0]};
    b.rq_wr_data = {m_dat[1], m_dat[0]};
    b.rq_byte_enable = {m_be[1], m_be[0]};
  endtask
  task automatic set_req(input bit p, input bit wr, input bit rd);
    m_wr[p] = wr;
    m_rd[p] = rd;
    m_adr[p] = 25'($urandom);
    m_dat[p] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    m_be[p] = $urandom;
    drive();
  endtask
  task automatic cyc();
    @(posedge avalon_clk);
    #1;
  endtask
  task automatic do_reset();
    avalon_reset = 1'b1;
    m_wr = '0;
    m_rd = '0;
    m_prio = 1'b0;
    drive();
    b.rd_valid = 1'b0;
    b.rd_data = '0;
    b.action_done = 1'b0;
    cyc();
    cyc();
    avalon_reset = 1'b0;
  endtask
  // One whole transaction: ack, command, DDR response after lat cycles (never if lat > TMO), done.
  task automatic serve(input int lat, input logic [255:0] rdd, output bit gp, output bit gw);
    bit p, w, stray;
    int k, kexp;
    logic [1:0] oh;
    p = ((m_wr | m_rd) == 2'b11) ? m_prio : (m_wr[1] | m_rd[1]);
    w = m_wr[p];
    oh = p ? 2'b10 : 2'b01;
    k = 0;
    do begin cyc(); k++; end while (b.rq_ack == 2'b00 && k < 8);
    check("ack_latency", k, 1);
    check("ack", b.rq_ack, oh);
    check("wr_rq", b.wr_rq, w);
    check("rd_rq", b.rd_rq, !w);
    check("wr_adr", b.wr_adr, m_adr[p]);
    check("rd_adr", b.rd_adr, m_adr[p]);
    check("wr_data", b.wr_data, m_dat[p]);
    check("byte_enable", b.byte_enable, m_be[p]);
    check("grant", b.grant, p);
    check("busy", b.busy, 1);
    if (w) m_wr[p] = 1'b0; else m_rd[p] = 1'b0;
    drive();
    b.action_done = 1'b1;
    b.rd_valid = 1'b1;
    b.rd_data = ~rdd;
    kexp = (lat > TMO) ? TMO + 1 : lat + 1;
    stray = 1'b0;
    k = 0;
    do begin
      cyc();
      k++;
      if (b.rq_ack != 2'b00 || b.wr_rq || b.rd_rq) stray = 1'b1;
      if (k == 1) begin
        check("rdv_issue_drop", b.rq_rd_valid, 0);
        b.rd_valid = 1'b1;
        b.rd_data = rdd;
      end else if (k == 2) begin
        check("rd_valid_route", b.rq_rd_valid, w ? 2'b00 : oh);
        if (!w) check("rd_data", b.rq_rd_data, rdd);
        b.rd_valid = 1'b0;
      end
      b.action_done = (k == lat);
    end while (b.rq_done == 2'b00 && k < TMO + 8);
    b.action_done = 1'b0;
    check("done_time", k, kexp);
    check("done", b.rq_done, oh);
    check("err", b.rq_err, (lat > TMO) ? oh : 2'b00);
    check("busy_end", b.busy, 0);
    check("no_stray", stray, 0);
    m_prio = !p;
    gp = p;
    gw = w;
  endtask
  initial begin
    bit gp, gw, flag;
    int k;
    logic [2:0] r;
    do_reset();
    check("reset_pulses", {b.rq_ack, b.rq_done, b.rq_err, b.rq_rd_valid, b.wr_rq, b.rd_rq}, 0);
    check("reset_state", {b.busy, b.grant, b.wr_adr, b.byte_enable}, 0);
    check("reset_data", {b.wr_data, b.rq_rd_data}, 0);
    // single write from port 0 with fixed fields
    set_req(0, 1, 0);
    m_adr[0] = 25'h10;
    m_dat[0] = {32{8'hA5}};
    m_be[0] = '1;
    drive();
    serve(5, 256'h0, gp, gw);
    check("t1_grant", gp, 0);
    // simultaneous writes after reset: port 0 first, then alternation while both stay requesting
    do_reset();
    set_req(0, 1, 0);
    set_req(1, 1, 0);
    for (int i = 0; i < 6; i++) begin
      serve($urandom_range(2, 6), 256'h0, gp, gw);
      check("rr_grant", gp, i % 2);
      if (i < 4) set_req(gp, 1, 0);
    end
    // read from port 1
    set_req(1, 0, 1);
    m_adr[1] = 25'h1FF;
    drive();
    serve(4, 256'h1234, gp, gw);
    check("t4_grant", gp, 1);
    // watchdog abort, exact-boundary success, then a normal transaction
    set_req(0, 1, 0);
    serve(1000, 256'h0, gp, gw);
    set_req(1, 0, 1);
    serve(TMO, 256'hBEEF, gp, gw);
    set_req(0, 0, 1);
    serve(3, 256'hCAFE, gp, gw);
    // reset while waiting on the DDR
    set_req(1, 1, 0);
    k = 0;
    do begin cyc(); k++; end while (b.rq_ack == 2'b00 && k < 8);
    check("rst_ack", b.rq_ack, 2'b10);
    m_wr[1] = 1'b0;
    drive();
    repeat (3) cyc();
    avalon_reset = 1'b1;
    cyc();
    avalon_reset = 1'b0;
    m_prio = 1'b0;
    check("rst_busy", b.busy, 0);
    check("rst_pulses", {b.rq_ack, b.rq_done, b.rq_err, b.wr_rq, b.rd_rq}, 0);
    flag = 1'b0;
    repeat (5) begin cyc(); if (b.rq_done != 2'b00 || b.busy) flag = 1'b1; end
    check("rst_quiet", flag, 0);
    // one port raising write and read together
    set_req(0, 1, 1);
    serve(3, 256'h0, gp, gw);
    check("wrrd_first_is_write", gw, 1);
    serve(3, 256'h77, gp, gw);
    check("wrrd_second_is_read", gw, 0);
    check("wrrd_port", gp, 0);
    // randomized traffic
    for (int i = 0; i < 24; i++) begin
      for (int p = 0; p < 2; p++)
        if (!(m_wr[p] | m_rd[p]) && $urandom_range(0, 1) == 1) begin
          r = 3'($urandom_range(1, 3));
          set_req(p[0], r[0], r[1]);
        end
      if ((m_wr | m_rd) == 2'b00) set_req($urandom_range(0, 1) == 1, 1'b0, 1'b1);
      serve($urandom_range(2, 10), {$urandom, $urandom}, gp, gw);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
